tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one serial transmitter.
REQ-002 Parameter DATA_W, default 10: frame width, equal to the transmitter data width.
REQ-003 Parameter TIMEOUT, default 16: maximum WAIT cycles allowed for a transmitter done pulse.
REQ-004 i_clk  in  1: single clock; all logic is on the rising edge.
REQ-005 i_rst  in  1: asynchronous, active-high reset.
REQ-006 i_req  in  NUM_REQ: per-requester request level, held until its o_grant.
REQ-007 i_data  in  NUM_REQ*DATA_W: flattened frames; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 o_grant  out  NUM_REQ: one-hot, one-cycle pulse when a frame is accepted.
REQ-009 o_done  out  NUM_REQ: one-hot, one-cycle pulse when that requester's frame completes.
REQ-010 o_err  out  1: one-cycle pulse on a transmitter timeout.
REQ-011 o_busy  out  1: high in every state except IDLE.
REQ-012 o_tx_ena_n  out  1: active-low start strobe to the transmitter.
REQ-013 o_tx_data  out  DATA_W: frame presented to the transmitter.
REQ-014 i_tx_done  in  1: transmitter completion pulse.

Function
REQ-015 The FSM SHALL have four states: IDLE, START, WAIT and GAP.
REQ-016 In IDLE with any i_req bit high, the arbiter SHALL select the lowest index at or above rr_ptr (with wrap-around), latch that slice into o_tx_data, pulse o_grant, drive o_tx_ena_n low and go to START.
REQ-017 Timing: a request sampled in cycle T SHALL produce o_grant and o_tx_ena_n=0 together in cycle T+1, and only in that cycle.
REQ-018 START SHALL last exactly one cycle, then go to WAIT with o_tx_ena_n high and the timeout counter at 0.
REQ-019 o_tx_data SHALL stay stable from the grant until the state leaves WAIT.
REQ-020 In WAIT, i_tx_done=1 SHALL pulse o_done[idx] in the next cycle, set rr_ptr to (idx+1) mod NUM_REQ and go to GAP.
REQ-021 With the default transmitter, a grant in cycle T+1 gives i_tx_done in T+12 and o_done in T+13; the earliest next grant is T+15.
REQ-022 In WAIT, if the counter reaches TIMEOUT-1 without i_tx_done, the arbiter SHALL pulse o_err, advance rr_ptr as in REQ-020 and go to GAP; no o_done is issued.
REQ-023 If i_tx_done and the timeout occur in the same cycle, done SHALL take priority and o_err SHALL stay low.
REQ-024 GAP SHALL last exactly one cycle with o_tx_ena_n high, then go to IDLE.
REQ-025 i_tx_done arriving outside WAIT SHALL be ignored.
REQ-026 i_req SHALL be sampled only in IDLE; a request dropped before its grant transfers nothing.
REQ-027 A requester whose request is continuously held SHALL be granted within NUM_REQ transfers.
REQ-028 The timeout counter width SHALL be $clog2(TIMEOUT)+1, and the counter SHALL saturate rather than wrap.

Reset
REQ-029 Reset SHALL force: state IDLE, o_tx_ena_n=1, o_tx_data=0, o_grant=0, o_done=0, o_err=0, o_busy=0, rr_ptr=0, counter=0.
REQ-030 Reset mid-transfer SHALL abort the transfer with no o_done or o_err pulse.
REQ-031 After reset release, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-032 A shared package tx_pkg SHALL hold the DATA_W default, the NUM_REQ default and the FSM state enum.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_select(req, ptr -> one-hot grant, index).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single request: i_req=0001, data 0x2A5 -> grant 0001 at T+1; transmitter shifts 0x2A5 LSB first; o_done=0001 at T+13.
REQ-036 All four requesting continuously -> grant order 0, 1, 2, 3, 0; each frame is correct on the serial line.
REQ-037 Stub transmitter that never returns done -> o_err pulses 16 cycles after START; rr_ptr advances; next grant goes to the next requester.
REQ-038 i_tx_done coincident with the final timeout cycle -> o_done pulses and o_err stays 0.
REQ-039 i_rst asserted in WAIT -> outputs return to reset values immediately, o_tx_ena_n=1, and no done or error pulse appears.
REQ-040 Spurious i_tx_done in IDLE and in GAP -> no o_done pulse and no state change.

Source files
------------

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit arbiter: default sizes, FSM states
// and the round-robin pointer helper.
package tx_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DATA_W  = 10;
    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Next requester after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_select.sv
// Combinational round-robin picker: the first requester at or above ptr,
// wrapping around, as a one-hot grant plus its binary index.
module rr_select #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    localparam int PW = IDX_W + 1;

    always_comb begin
        logic          found;
        logic [PW-1:0] pos;
        grant = '0;
        index = '0;
        found = 1'b0;
        pos   = '0;
        // One extra bit holds ptr+off before the wrap subtraction.
        for (int off = 0; off < N; off++) begin
            pos = {1'b0, ptr} + PW'(off);
            if (pos >= PW'(N)) begin
                pos = pos - PW'(N);
            end
            if (!found && req[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                grant[pos[IDX_W-1:0]] = 1'b1;
                index                 = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between NUM_REQ
// requesters, with a bounded wait for the transmitter's done pulse.
module tx_arbiter
    import tx_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*DATA_W-1:0] i_data,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [NUM_REQ-1:0]        o_done,
    output logic                      o_err,
    output logic                      o_busy,
    output logic                      o_tx_ena_n,
    output logic [DATA_W-1:0]         o_tx_data,
    input  logic                      i_tx_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t               state, state_d;
    logic                 ready, ready_d;
    logic [IDX_W-1:0]     ptr, ptr_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [NUM_REQ-1:0]   owner, owner_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_REQ-1:0]   grant, grant_d;
    logic [NUM_REQ-1:0]   done, done_d;
    logic                 err, err_d;
    logic                 busy, busy_d;
    logic                 tx_ena_n, tx_ena_n_d;
    logic [DATA_W-1:0]    tx_data, tx_data_d;

    logic [NUM_REQ-1:0]   sel_grant;
    logic [IDX_W-1:0]     sel_idx;

    rr_select #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (i_req),
        .ptr   (ptr),
        .grant (sel_grant),
        .index (sel_idx)
    );

    // ready holds off arbitration for the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            ready    <= 1'b0;
            ptr      <= '0;
            idx      <= '0;
            owner    <= '0;
            cnt      <= '0;
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            tx_ena_n <= 1'b1;
            tx_data  <= '0;
        end else begin
            state    <= state_d;
            ready    <= ready_d;
            ptr      <= ptr_d;
            idx      <= idx_d;
            owner    <= owner_d;
            cnt      <= cnt_d;
            grant    <= grant_d;
            done     <= done_d;
            err      <= err_d;
            busy     <= busy_d;
            tx_ena_n <= tx_ena_n_d;
            tx_data  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state;
        ready_d    = 1'b1;
        ptr_d      = ptr;
        idx_d      = idx;
        owner_d    = owner;
        cnt_d      = cnt;
        grant_d    = '0;
        done_d     = '0;
        err_d      = 1'b0;
        tx_ena_n_d = 1'b1;
        tx_data_d  = tx_data;

        case (state)
            ST_IDLE: begin
                if (ready && (|i_req)) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (sel_grant[k]) begin
                            tx_data_d = i_data[k*DATA_W +: DATA_W];
                        end
                    end
                    idx_d      = sel_idx;
                    owner_d    = sel_grant;
                    grant_d    = sel_grant;
                    tx_ena_n_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a timeout landing in the same cycle.
                if (i_tx_done) begin
                    done_d  = owner;
                    ptr_d   = IDX_W'(wrap_inc(int'(idx), NUM_REQ));
                    state_d = ST_GAP;
                end else if (cnt == CNT_LAST) begin
                    err_d   = 1'b1;
                    ptr_d   = IDX_W'(wrap_inc(int'(idx), NUM_REQ));
                    state_d = ST_GAP;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign o_grant    = grant;
    assign o_done     = done;
    assign o_err      = err;
    assign o_busy     = busy;
    assign o_tx_ena_n = tx_ena_n;
    assign o_tx_data  = tx_data;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: a serial transmitter model plus a
// scoreboard of expected grants and completions.
module tb_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 10;

    typedef struct {
        logic [NR-1:0] grant;
        logic [DW-1:0] data;
        logic          is_err;
    } sb_item_t;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    done;
    logic             err;
    logic             busy;
    logic             tx_ena_n;
    logic [DW-1:0]    tx_data;
    logic             tx_done;

    logic             model_done;
    logic             spur_done;
    logic             tx_on;
    int               tx_k;
    int               tx_delay;
    int               cur_delay;
    logic [DW-1:0]    rx_frame;

    int               cyc;
    int               n_checks;
    int               n_fail;
    sb_item_t         gnt_q[$];
    sb_item_t         inflight[$];
    sb_item_t         mon_item;
    logic [DW-1:0]    frame [NR];

    assign tx_done = model_done | spur_done;

    tx_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_data     (data),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .o_tx_ena_n (tx_ena_n),
        .o_tx_data  (tx_data),
        .i_tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: after the start strobe, one bit per edge LSB first, done
    // pulse raised tx_delay edges later (0 never answers).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_on      <= 1'b0;
            tx_k       <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (!tx_ena_n) begin
                tx_on     <= 1'b1;
                tx_k      <= 0;
                rx_frame  <= '0;
                cur_delay <= tx_delay;
            end else if (tx_on) begin
                if (tx_k < DW) rx_frame[tx_k] <= tx_data[tx_k];
                tx_k <= tx_k + 1;
                if (tx_k + 1 == cur_delay) begin
                    model_done <= 1'b1;
                    tx_on      <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [NR-1:0] r);
        req = r;
    endtask

    function automatic void expectXfer(input int k, input logic is_err);
        sb_item_t it;
        it.grant  = 4'b0001 << k;
        it.data   = frame[k];
        it.is_err = is_err;
        gnt_q.push_back(it);
    endfunction

    task automatic waitGrant(output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant == 0 && n < 40);
        checkOutput("grant_seen", grant != 0, 1);
        at = cyc;
    endtask

    task automatic waitDone(output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == 0 && !err && n < 40);
        checkOutput("done_or_err_seen", (done != 0) || err, 1);
        at = cyc;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_grant"}, grant, 0);
        checkOutput({pfx, "_done"}, done, 0);
        checkOutput({pfx, "_err"}, err, 0);
        checkOutput({pfx, "_busy"}, busy, 0);
        checkOutput({pfx, "_ena_n"}, tx_ena_n, 1);
        checkOutput({pfx, "_tx_data"}, tx_data, 0);
    endtask

    // Scoreboard monitor: grants pop the expected queue, completions pop
    // the in-flight queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (grant != 0) begin
                if (gnt_q.size() == 0) begin
                    checkOutput("unexpected_grant", grant, 0);
                end else begin
                    mon_item = gnt_q.pop_front();
                    checkOutput("grant", grant, mon_item.grant);
                    checkOutput("grant_ena_n", tx_ena_n, 0);
                    checkOutput("grant_data", tx_data, mon_item.data);
                    inflight.push_back(mon_item);
                end
            end
            if (done != 0 || err) begin
                if (inflight.size() == 0) begin
                    checkOutput("unexpected_done_err", {done, err}, 0);
                end else begin
                    mon_item = inflight.pop_front();
                    checkOutput("done", done, mon_item.is_err ? 4'b0000 : mon_item.grant);
                    checkOutput("err", err, mon_item.is_err);
                    if (!mon_item.is_err) checkOutput("frame", rx_frame, mon_item.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g, d, prev, pulses;
        clk       = 1'b0;
        rst       = 1'b1;
        req       = '0;
        spur_done = 1'b0;
        tx_delay  = 10;
        cyc       = 0;
        n_checks  = 0;
        n_fail    = 0;
        frame[0]  = 10'h2A5;
        frame[1]  = 10'h0CA;
        frame[2]  = 10'h3F0;
        frame[3]  = 10'h155;
        for (int k = 0; k < NR; k++) data[k*DW +: DW] = frame[k];

        repeat (2) @(negedge clk);
        checkResetValues("reset");

        // Single request held through reset release.
        $display("[TB] single request");
        expectXfer(0, 1'b0);
        applyStimulus(4'b0001);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_edge_grant", grant, 0);
        waitGrant(g);
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("grant_pulse_width", grant, 0);
        checkOutput("ena_pulse_width", tx_ena_n, 1);
        checkOutput("start_busy", busy, 1);
        waitDone(d);
        checkOutput("done_latency", d - g, 12);

        // Spurious done in GAP and then IDLE.
        spur_done = 1'b1;
        @(negedge clk);
        checkOutput("spur_gap_done", done, 0);
        checkOutput("spur_gap_busy", busy, 0);
        @(negedge clk);
        checkOutput("spur_idle_done", done, 0);
        checkOutput("spur_idle_busy", busy, 0);
        spur_done = 1'b0;
        @(negedge clk);
        checkOutput("spur_after_busy", busy, 0);

        // All four requesting from a fresh pointer.
        $display("[TB] round robin");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expectXfer(0, 1'b0);
        expectXfer(1, 1'b0);
        expectXfer(2, 1'b0);
        expectXfer(3, 1'b0);
        expectXfer(0, 1'b0);
        applyStimulus(4'b1111);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            waitGrant(g);
            if (i == 4) applyStimulus(4'b0000);
            if (i > 0) checkOutput("grant_spacing", g - prev, 14);
            prev = g;
            waitDone(d);
        end

        // Silent transmitter times out; pointer moves on to requester 2.
        $display("[TB] timeout");
        tx_delay = 0;
        expectXfer(1, 1'b1);
        expectXfer(2, 1'b0);
        applyStimulus(4'b0110);
        waitGrant(g);
        applyStimulus(4'b0100);
        waitDone(d);
        checkOutput("err_latency", d - g, 17);
        tx_delay = 10;
        waitGrant(g);
        applyStimulus(4'b0000);
        waitDone(d);

        // Done arrives in the last allowed WAIT cycle.
        $display("[TB] done at timeout edge");
        tx_delay = 15;
        expectXfer(3, 1'b0);
        applyStimulus(4'b1000);
        waitGrant(g);
        applyStimulus(4'b0000);
        waitDone(d);
        checkOutput("late_done_latency", d - g, 17);
        tx_delay = 10;

        // Reset while waiting aborts the transfer silently.
        $display("[TB] reset in WAIT");
        expectXfer(0, 1'b0);
        applyStimulus(4'b0001);
        waitGrant(g);
        applyStimulus(4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("wait_busy", busy, 1);
        rst = 1'b1;
        #1;
        checkResetValues("abort");
        inflight.delete();
        repeat (12) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done != 0 || err || grant != 0) pulses++;
        end
        checkOutput("abort_no_pulse", pulses, 0);
        checkOutput("sb_empty", gnt_q.size() + inflight.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
